// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter with a stall watchdog in front of one slave.
// Latency: grant one cycle after cyc rise; granted request/response paths are combinational.
// Backpressure: the owner sees the slave stall directly; the non-owner is held stalled until it is granted.
module wb_bus_arbiter #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_wb_cyc,
    input  logic              m0_wb_stb,
    input  logic              m0_wb_we,
    input  logic [ADDR_W-1:0] m0_wb_addr,
    input  logic [DATA_W-1:0] m0_wb_data,
    output logic              m0_wb_ack,
    output logic              m0_wb_stall,
    output logic [DATA_W-1:0] m0_wb_rdata,
    input  logic              m1_wb_cyc,
    input  logic              m1_wb_stb,
    input  logic              m1_wb_we,
    input  logic [ADDR_W-1:0] m1_wb_addr,
    input  logic [DATA_W-1:0] m1_wb_data,
    output logic              m1_wb_ack,
    output logic              m1_wb_stall,
    output logic [DATA_W-1:0] m1_wb_rdata,
    output logic              s_wb_cyc,
    output logic              s_wb_stb,
    output logic              s_wb_we,
    output logic [ADDR_W-1:0] s_wb_addr,
    output logic [DATA_W-1:0] s_wb_data,
    input  logic              s_wb_ack,
    input  logic              s_wb_stall,
    input  logic [DATA_W-1:0] s_wb_rdata,
    output logic [1:0]        grant,
    output logic              timeout_err,
    output logic [7:0]        err_count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2,
        S_ABORT  = 2'd3
    } state_t;

    state_t            state;
    logic              last_owner;
    logic [WD_W-1:0]   wd_cnt;

    // Owner of the current or just-aborted cycle is whoever was granted last.
    logic own_cyc;
    logic other_cyc;
    logic stalled;
    logic wd_fire;

    assign own_cyc   = last_owner ? m1_wb_cyc : m0_wb_cyc;
    assign other_cyc = last_owner ? m0_wb_cyc : m1_wb_cyc;
    assign stalled   = s_wb_cyc & s_wb_stall;
    assign wd_fire   = stalled && (wd_cnt == WD_W'(TIMEOUT - 1));

    // Arbitration state, ownership history, watchdog and error accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_owner  <= 1'b1;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    wd_cnt <= '0;
                    if (m0_wb_cyc && (!m1_wb_cyc || last_owner)) begin
                        state      <= S_GRANT0;
                        last_owner <= 1'b0;
                    end else if (m1_wb_cyc) begin
                        state      <= S_GRANT1;
                        last_owner <= 1'b1;
                    end
                end
                S_GRANT0, S_GRANT1: begin
                    // A release always wins over a watchdog abort in the same cycle.
                    if (!own_cyc) begin
                        wd_cnt <= '0;
                        if (other_cyc) begin
                            state      <= last_owner ? S_GRANT0 : S_GRANT1;
                            last_owner <= ~last_owner;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (wd_fire) begin
                        state       <= S_ABORT;
                        wd_cnt      <= '0;
                        timeout_err <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end else if (stalled) begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end else begin
                        wd_cnt <= '0;
                    end
                end
                default: begin
                    // Hold the bus idle until the hung master lets go of cyc.
                    wd_cnt <= '0;
                    if (!own_cyc) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Route the owner's request to the slave and the slave's response back to the owner.
    always_comb begin
        s_wb_cyc    = 1'b0;
        s_wb_stb    = 1'b0;
        s_wb_we     = 1'b0;
        s_wb_addr   = '0;
        s_wb_data   = '0;
        m0_wb_ack   = 1'b0;
        m0_wb_stall = 1'b1;
        m0_wb_rdata = '0;
        m1_wb_ack   = 1'b0;
        m1_wb_stall = 1'b1;
        m1_wb_rdata = '0;
        grant       = 2'b00;
        case (state)
            S_GRANT0: begin
                s_wb_cyc    = m0_wb_cyc;
                s_wb_stb    = m0_wb_stb;
                s_wb_we     = m0_wb_we;
                s_wb_addr   = m0_wb_addr;
                s_wb_data   = m0_wb_data;
                m0_wb_ack   = s_wb_ack;
                m0_wb_stall = s_wb_stall;
                m0_wb_rdata = s_wb_rdata;
                grant       = 2'b01;
            end
            S_GRANT1: begin
                s_wb_cyc    = m1_wb_cyc;
                s_wb_stb    = m1_wb_stb;
                s_wb_we     = m1_wb_we;
                s_wb_addr   = m1_wb_addr;
                s_wb_data   = m1_wb_data;
                m1_wb_ack   = s_wb_ack;
                m1_wb_stall = s_wb_stall;
                m1_wb_rdata = s_wb_rdata;
                grant       = 2'b10;
            end
            default: begin
            end
        endcase
    end

endmodule
